// File: rtl/hazard_scoreboard_if.sv
// ID-stage <-> hazard scoreboard bundle: source operands, issue info
// going in; stall, per-port hazard flags and per-register busy coming back.
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_W = 4,
    parameter int NUM_SRC    = 3
);
    logic [NUM_SRC*REG_ADDR_W-1:0] src;
    logic [NUM_SRC-1:0]            src_used;
    logic                          issue_valid;
    logic                          issue_wb_en;
    logic [REG_ADDR_W-1:0]         issue_dest;
    logic                          issue_is_load;
    logic                          forwarding_en;
    logic                          flush;
    logic                          stall;
    logic [NUM_SRC-1:0]            hazard_src;
    logic [(1<<REG_ADDR_W)-1:0]    busy;

    modport master (
        output src, src_used, issue_valid, issue_wb_en,
        output issue_dest, issue_is_load, forwarding_en, flush,
        input  stall, hazard_src, busy
    );

    modport slave (
        input  src, src_used, issue_valid, issue_wb_en,
        input  issue_dest, issue_is_load, forwarding_en, flush,
        output stall, hazard_src, busy
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write scoreboard with countdown timers for ID stalls.
// Optional HAZARD_STATS_EN adds stall_cycles / hazard_events counters.
module hazard_scoreboard #(
    parameter int REG_ADDR_W   = 4,
    parameter int NUM_SRC      = 3,
    parameter int NOFWD_LAT    = 2,
    parameter int FWD_ALU_LAT  = 0,
    parameter int FWD_LOAD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef HAZARD_STATS_EN
    output logic [31:0]         stall_cycles,
    output logic [31:0]         hazard_events,
`endif
    hazard_scoreboard_if.slave  bus
);

    localparam int NREG = 1 << REG_ADDR_W;
    localparam int MAX_AB =
        (NOFWD_LAT > FWD_ALU_LAT) ? NOFWD_LAT : FWD_ALU_LAT;
    localparam int MAXL =
        (MAX_AB > FWD_LOAD_LAT) ? MAX_AB : FWD_LOAD_LAT;
    localparam int CW = (MAXL < 1) ? 1 : $clog2(MAXL + 1);

    localparam logic [CW-1:0] L_NOFWD = CW'(NOFWD_LAT);
    localparam logic [CW-1:0] L_ALU   = CW'(FWD_ALU_LAT);
    localparam logic [CW-1:0] L_LOAD  = CW'(FWD_LOAD_LAT);

    logic [CW-1:0]      cnt     [NREG];
    logic [CW-1:0]      cnt_nxt [NREG];
    logic [NUM_SRC-1:0] hz;
    logic [NREG-1:0]    busy_w;
    logic [CW-1:0]      lat;
    logic               stall_w;
    logic               fire;

    always_comb begin
        hz = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.src_used[i] &&
                cnt[bus.src[i*REG_ADDR_W +: REG_ADDR_W]] != '0)
                hz[i] = 1'b1;
        end
    end

    always_comb begin
        busy_w = '0;
        for (int r = 0; r < NREG; r++)
            busy_w[r] = (cnt[r] != '0);
    end

    assign stall_w = bus.issue_valid & ~bus.flush & (|hz);
    assign fire    = bus.issue_valid & ~bus.flush & ~stall_w;

    assign bus.stall      = stall_w;
    assign bus.hazard_src = hz;
    assign bus.busy       = busy_w;

    always_comb begin
        lat = L_NOFWD;
        unique case (1'b1)
            ~bus.forwarding_en:                     lat = L_NOFWD;
            bus.forwarding_en &  bus.issue_is_load: lat = L_LOAD;
            bus.forwarding_en & ~bus.issue_is_load: lat = L_ALU;
        endcase
    end

    // max(dec, lat) keeps an older, longer write pending
    always_comb begin
        logic [CW-1:0] dec;
        dec = '0;
        for (int r = 0; r < NREG; r++) begin
            dec = (cnt[r] == '0) ? '0 : cnt[r] - CW'(1);
            cnt_nxt[r] = dec;
            if (fire && bus.issue_wb_en &&
                bus.issue_dest == REG_ADDR_W'(r) && lat > dec)
                cnt_nxt[r] = lat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++)
                cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++)
                cnt[r] <= cnt_nxt[r];
        end
    end

`ifdef HAZARD_STATS_EN
    logic stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q       <= 1'b0;
            stall_cycles  <= '0;
            hazard_events <= '0;
        end else begin
            stall_q <= stall_w;
            if (stall_w)
                stall_cycles <= stall_cycles + 32'd1;
            if (stall_w && !stall_q)
                hazard_events <= hazard_events + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: vector table, reset/stats sequences,
// then random traffic against a ready-time reference model.
module tb_hazard_scoreboard;

    localparam int W    = 4;
    localparam int NS   = 3;
    localparam int NREG = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_ADDR_W(W), .NUM_SRC(NS)) bus ();

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] hazard_events;
`endif

    hazard_scoreboard #(
        .REG_ADDR_W(W), .NUM_SRC(NS),
        .NOFWD_LAT(2), .FWD_ALU_LAT(0), .FWD_LOAD_LAT(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef HAZARD_STATS_EN
        .stall_cycles(stall_cycles),
        .hazard_events(hazard_events),
`endif
        .bus(bus.slave)
    );

    typedef struct {
        logic [11:0] src;
        logic [2:0]  used;
        logic        v;
        logic        wb;
        logic [3:0]  dest;
        logic        ld;
        logic        fwd;
        logic        fl;
        logic        e_stall;
        logic [2:0]  e_hz;
        logic [15:0] e_busy;
    } vec_t;

    vec_t tbl [16];

    // reference model: cycle at which each register's write is usable
    int ready_at [NREG];
    int now;

    function automatic vec_t mk(
        logic [11:0] s, logic [2:0] u, logic v, logic wb,
        logic [3:0] d, logic ld, logic fwd, logic fl,
        logic es, logic [2:0] eh, logic [15:0] eb);
        vec_t t;
        t.src = s; t.used = u; t.v = v; t.wb = wb;
        t.dest = d; t.ld = ld; t.fwd = fwd; t.fl = fl;
        t.e_stall = es; t.e_hz = eh; t.e_busy = eb;
        return t;
    endfunction

    task automatic chk(input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [11:0] s, input logic [2:0] u,
                         input logic v, input logic wb,
                         input logic [3:0] d, input logic ld,
                         input logic fwd, input logic fl);
        bus.src = s; bus.src_used = u; bus.issue_valid = v;
        bus.issue_wb_en = wb; bus.issue_dest = d;
        bus.issue_is_load = ld; bus.forwarding_en = fwd;
        bus.flush = fl;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive('0, '0, 0, 0, '0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic model_clear();
        for (int r = 0; r < NREG; r++) ready_at[r] = 0;
    endtask

    // expected outputs from the model for the currently driven inputs
    task automatic model_eval(output logic e_stall,
                              output logic [2:0] e_hz,
                              output logic [15:0] e_busy);
        int s;
        e_hz = '0;
        for (int i = 0; i < NS; i++) begin
            s = int'(bus.src[i*W +: W]);
            if (bus.src_used[i] && ready_at[s] > now) e_hz[i] = 1'b1;
        end
        for (int r = 0; r < NREG; r++) e_busy[r] = ready_at[r] > now;
        e_stall = bus.issue_valid && !bus.flush && (e_hz != 0);
    endtask

    task automatic model_issue(input logic e_stall);
        int lat;
        int d;
        if (bus.issue_valid && !bus.flush && !e_stall && bus.issue_wb_en) begin
            if (!bus.forwarding_en) lat = 2;
            else if (bus.issue_is_load) lat = 1;
            else lat = 0;
            d = int'(bus.issue_dest);
            if (now + 1 + lat > ready_at[d]) ready_at[d] = now + 1 + lat;
        end
    endtask

    initial begin
        logic        es;
        logic [2:0]  eh;
        logic [15:0] eb;
        logic [11:0] rs;

        drive('0, '0, 0, 0, '0, 0, 0, 0);
        #3;
        chk("reset_stall", 32'(bus.stall), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_hz", 32'(bus.hazard_src), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        tbl[0]  = mk(12'h000, 3'b000, 1, 1, 4'd3, 0, 0, 0, 0, 3'b000, 16'h0000);
        tbl[1]  = mk(12'h003, 3'b001, 1, 0, 4'd0, 0, 0, 0, 1, 3'b001, 16'h0008);
        tbl[2]  = mk(12'h003, 3'b001, 1, 0, 4'd0, 0, 0, 0, 1, 3'b001, 16'h0008);
        tbl[3]  = mk(12'h003, 3'b001, 1, 0, 4'd0, 0, 0, 0, 0, 3'b000, 16'h0000);
        tbl[4]  = mk(12'h000, 3'b000, 1, 1, 4'd5, 1, 1, 0, 0, 3'b000, 16'h0000);
        tbl[5]  = mk(12'h005, 3'b001, 1, 1, 4'd6, 0, 1, 0, 1, 3'b001, 16'h0020);
        tbl[6]  = mk(12'h005, 3'b001, 1, 1, 4'd6, 0, 1, 0, 0, 3'b000, 16'h0000);
        tbl[7]  = mk(12'h006, 3'b001, 1, 0, 4'd0, 0, 1, 0, 0, 3'b000, 16'h0000);
        tbl[8]  = mk(12'h000, 3'b000, 1, 1, 4'd2, 1, 0, 0, 0, 3'b000, 16'h0000);
        tbl[9]  = mk(12'h000, 3'b000, 1, 1, 4'd2, 0, 1, 0, 0, 3'b000, 16'h0004);
        tbl[10] = mk(12'h020, 3'b010, 0, 0, 4'd0, 0, 0, 0, 0, 3'b010, 16'h0004);
        tbl[11] = mk(12'h020, 3'b010, 0, 0, 4'd0, 0, 0, 0, 0, 3'b000, 16'h0000);
        tbl[12] = mk(12'h000, 3'b000, 1, 1, 4'd5, 0, 0, 0, 0, 3'b000, 16'h0000);
        tbl[13] = mk(12'h050, 3'b001, 1, 0, 4'd0, 0, 0, 0, 0, 3'b000, 16'h0020);
        tbl[14] = mk(12'h050, 3'b010, 1, 1, 4'd9, 0, 0, 1, 0, 3'b010, 16'h0020);
        tbl[15] = mk(12'h000, 3'b000, 0, 0, 4'd0, 0, 0, 0, 0, 3'b000, 16'h0000);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(tbl[i].src, tbl[i].used, tbl[i].v, tbl[i].wb,
                  tbl[i].dest, tbl[i].ld, tbl[i].fwd, tbl[i].fl);
            #1;
            chk($sformatf("vec%0d_stall", i), 32'(bus.stall), 32'(tbl[i].e_stall));
            chk($sformatf("vec%0d_hz", i), 32'(bus.hazard_src), 32'(tbl[i].e_hz));
            chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(tbl[i].e_busy));
        end

        // asynchronous reset while R3 is pending
        do_reset();
        @(negedge clk);
        drive(12'h000, 3'b000, 1, 1, 4'd3, 0, 0, 0);
        @(negedge clk);
        drive(12'h003, 3'b001, 1, 0, 4'd0, 0, 0, 0);
        #1;
        chk("pre_rst_stall", 32'(bus.stall), 32'd1);
        chk("pre_rst_busy", 32'(bus.busy), 32'h8);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_stall", 32'(bus.stall), 32'd0);
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        chk("async_rst_hz", 32'(bus.hazard_src), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_stall", 32'(bus.stall), 32'd0);

`ifdef HAZARD_STATS_EN
        do_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(12'h000, 3'b000, 1, 1, 4'(3 + k), 0, 0, 0);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                drive(12'(3 + k), 3'b001, 1, 0, 4'd0, 0, 0, 0);
            end
        end
        @(negedge clk);
        drive('0, '0, 0, 0, '0, 0, 0, 0);
        #1;
        chk("stall_cycles", stall_cycles, 32'd4);
        chk("hazard_events", hazard_events, 32'd2);
`endif

        // random traffic against the reference model
        do_reset();
        model_clear();
        now = 0;
        bus.forwarding_en = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            for (int i = 0; i < NS; i++)
                rs[i*W +: W] = 4'($urandom_range(0, 7));
            bus.src = rs;
            bus.src_used = 3'($urandom);
            bus.issue_valid = ($urandom_range(0, 9) < 8);
            bus.issue_wb_en = 1'($urandom);
            bus.issue_dest = 4'($urandom_range(0, 7));
            bus.issue_is_load = 1'($urandom);
            if ($urandom_range(0, 9) == 0)
                bus.forwarding_en = ~bus.forwarding_en;
            bus.flush = ($urandom_range(0, 9) == 0);
            #1;
            if (n % 700 == 350) begin
                rst_n = 1'b0;
                #1;
                chk("rnd_rst_busy", 32'(bus.busy), 32'd0);
                rst_n = 1'b1;
                model_clear();
            end
            model_eval(es, eh, eb);
            chk("rnd_stall", 32'(bus.stall), 32'(es));
            chk("rnd_hz", 32'(bus.hazard_src), 32'(eh));
            chk("rnd_busy", 32'(bus.busy), 32'(eb));
            model_issue(es);
            @(posedge clk);
            now++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the ID-stage hazard detector. Instead of comparing sources only against the EXE and MEM destinations, it keeps a per-register pending-write scoreboard with countdown timers. This supports any number of source operands, configurable pipeline depth and load-use latency, and partial-pipeline flush. It sits beside the ID stage and drives the IF/ID freeze and ID/EXE bubble insertion.

## Interface
Parameters:
- REG_ADDR_W, 4: register index width; the scoreboard holds 2**REG_ADDR_W entries.
- NUM_SRC, 3: number of source operand ports (Rn, Rm, Rs).
- NOFWD_LAT, 2: stall cycles after issue for any write when forwarding is off.
- FWD_ALU_LAT, 0: stall cycles after issue for a non-load write when forwarding is on.
- FWD_LOAD_LAT, 1: stall cycles after issue for a load write when forwarding is on.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- src, in, NUM_SRC*REG_ADDR_W: ID source indices; port i is at bits [i*REG_ADDR_W +: REG_ADDR_W].
- src_used, in, NUM_SRC: per-port "operand actually read" (generalises two_src).
- issue_valid, in, 1: ID holds a valid instruction that wants to advance.
- issue_wb_en, in, 1: the issuing instruction writes a register.
- issue_dest, in, REG_ADDR_W: destination of the issuing instruction.
- issue_is_load, in, 1: the issuing instruction is a memory read.
- forwarding_en, in, 1: forwarding unit active; sampled per issue.
- flush, in, 1: branch taken in EXE; the instruction in ID is squashed.
- stall, out, 1: freeze PC and IF/ID, insert bubble into ID/EXE.
- hazard_src, out, NUM_SRC: per-port hazard flag (debug and forwarding diagnostics).
- busy, out, 2**REG_ADDR_W: per-register pending flag (counter non-zero).

## Operation
- Per-register counter cnt[r]; width CW = clog2(max(NOFWD_LAT, FWD_ALU_LAT, FWD_LOAD_LAT)+1), minimum 1.
- Combinational:
  - hazard_src[i] = src_used[i] & (cnt[src[i]] != 0).
  - stall = issue_valid & ~flush & |hazard_src.
  - busy[r] = (cnt[r] != 0).
- issue_fire = issue_valid & ~flush & ~stall.
- Latency L selection, at issue: forwarding_en=0 gives NOFWD_LAT; forwarding_en=1 gives FWD_LOAD_LAT if issue_is_load, else FWD_ALU_LAT.
- Each edge, every register: dec = (cnt[r]==0) ? 0 : cnt[r]-1 (saturates at 0).
- If issue_fire & issue_wb_en & r==issue_dest: cnt[r] <= max(dec, L). Otherwise cnt[r] <= dec.
  - Taking the max keeps the older, longer write pending, e.g. an ALU write issued after an outstanding load.
- L = 0 sets nothing (counter only decrements).
- A hazard on an unused port (src_used[i]=0) is ignored whatever its index.
- flush: the squashed ID instruction never issues, so it never sets the scoreboard. stall is forced 0 in that cycle. Counters of already-issued instructions keep running.
- Changing forwarding_en mid-stream affects only subsequent issues; in-flight counters are unchanged.
- No self-dependency: an instruction's own destination is not checked against its own sources in the issue cycle, because the counter update lands at the edge.

## Timing
- Reset (rst_n low, asynchronous): all cnt = 0, so stall=0, hazard_src=0, busy=0 immediately. Release is synchronous to the next clk edge.
- Reset mid-operation discards all pending writes; the pipeline is reset together with this block.
- Issue at cycle t with latency L: cnt = L at t+1, decrementing to 0 at t+1+L.
- A dependent instruction in ID from t+1 stalls exactly L cycles.
- Outputs are combinational from registered state and current inputs. Zero-cycle path from src/src_used/issue_valid/flush to stall.
- Same-cycle issue and decrement on one register are resolved by the max rule; no lost update.

## Configuration
- HAZARD_STATS_EN defined:
  - Adds outputs stall_cycles (32) and hazard_events (32).
  - stall_cycles increments every cycle stall=1.
  - hazard_events increments on each rising edge of stall (stall=1 and previous stall=0).
  - Both counters reset to 0 by rst_n and wrap at 2**32.
- HAZARD_STATS_EN undefined: these ports and registers do not exist; behaviour is otherwise identical.

## Test plan
- Reset: drive rst_n=0 mid-pending (cnt[3]=2) -> stall=0, busy=0 asynchronously. After release, src0=3 with src_used=1 -> no stall.
- No forwarding: issue ADD R3 at t, then ID reads R3 from t+1 -> stall=1 at t+1 and t+2, 0 at t+3. busy[3] is 1 for 2 cycles.
- Forwarding, load-use: issue LDR R5 (forwarding_en=1), next instruction reads R5 -> exactly 1 stall cycle. Same sequence with ADD -> 0 stalls.
- Unused source and max rule: src1=R5 with src_used[1]=0 while busy -> no stall. LDR R2 (L=2, no forwarding) then ADD R2 with forwarding on (L=0) -> cnt[2] continues 2,1,0.
- Flush: hazard pending and flush=1 -> stall=0, and no counter is set by the squashed instruction even if issue_wb_en=1.
- HAZARD_STATS_EN: two separate 2-cycle stalls -> stall_cycles=4, hazard_events=2.
